// File: rtl/cenc_322_pkg.sv
// cenc_322_pkg: shared definitions for the rate-2/3 (3,2,2) convolutional encoder.
//   - code dimensions (N output bits, K input bits, M state bits)
//   - generator masks for c2/c1/c0 over the vector {u1,u0,s2,s1,s0}
//   - frame FSM state encoding
//   - enc_sym(): code symbol for a given input dibit and encoder state
package cenc_322_pkg;

    localparam int unsigned N        = 3;
    localparam int unsigned K        = 2;
    localparam int unsigned M        = 3;
    // Tail length equals the u1 memory depth; flushes the trellis back to state 0.
    localparam int unsigned TAIL_LEN = 2;

    // Generator masks over {u1,u0,s2,s1,s0}.
    localparam logic [4:0] GEN_C2 = 5'b10010;
    localparam logic [4:0] GEN_C1 = 5'b01101;
    localparam logic [4:0] GEN_C0 = 5'b11110;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StTail = 2'd2
    } fsm_e;

    function automatic logic [N-1:0] enc_sym(input logic [K-1:0] u, input logic [M-1:0] s);
        logic [K+M-1:0] vec;
        vec = {u, s};
        return {^(vec & GEN_C2), ^(vec & GEN_C1), ^(vec & GEN_C0)};
    endfunction

endpackage

// File: rtl/cenc_322_if.sv
// cenc_322_if: stream bundle around the encoder.
//   Din[1:0]   information dibit {u1,u0}     din_valid / din_ready  input handshake
//   Tx[2:0]    code symbol {c2,c1,c0}        tx_valid / tx_ready    output handshake
//   tx_first   first symbol of a frame       tx_last               final tail symbol
// master: the side that feeds dibits and sinks symbols.  slave: the encoder.
interface cenc_322_if;
    import cenc_322_pkg::*;

    logic [K-1:0] Din;
    logic         din_valid;
    logic         din_ready;
    logic [N-1:0] Tx;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_first;
    logic         tx_last;

    modport master (
        output Din, din_valid, tx_ready,
        input  din_ready, Tx, tx_valid, tx_first, tx_last
    );

    modport slave (
        input  Din, din_valid, tx_ready,
        output din_ready, Tx, tx_valid, tx_first, tx_last
    );

endinterface

// File: rtl/enc_trellis_322.sv
// enc_trellis_322: purely combinational trellis step of the (3,2,2) code.
//   u[1:0]      input dibit {u1,u0}
//   s[2:0]      current state {s2,s1,s0}
//   tx[2:0]     code symbol {c2,c1,c0}
//   s_next[2:0] next state: s2<=u1, s1<=s2, s0<=u0
// Also usable standalone as a golden model on the decoder side.
module enc_trellis_322
    import cenc_322_pkg::*;
(
    input  logic [K-1:0] u,
    input  logic [M-1:0] s,
    output logic [N-1:0] tx,
    output logic [M-1:0] s_next
);

    assign tx     = enc_sym(u, s);
    assign s_next = {u[1], s[2], u[0]};

endmodule

// File: rtl/cenc_322.sv
// cenc_322: framed rate-2/3, 8-state convolutional encoder.
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    cenc_322_if.slave: dibits in on Din/din_valid/din_ready, code symbols out on
//          Tx/tx_valid/tx_ready with tx_first/tx_last frame markers
// Each frame is FRAME_LEN data dibits followed by TAIL_LEN zero dibits, so the trellis ends
// in state 0 and the next frame starts from it without any explicit clear.
module cenc_322
    import cenc_322_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned CNT_W     = 10
) (
    input logic       clock,
    input logic       reset,
    cenc_322_if.slave bus
);

    localparam int unsigned TAIL_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam logic [TAIL_W-1:0] TAIL_END = TAIL_W'(TAIL_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(FRAME_LEN);

    fsm_e              fsm_q;
    logic [M-1:0]      s_q;
    logic [N-1:0]      tx_q;
    logic              tx_valid_q;
    logic              tx_first_q;
    logic              tx_last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TAIL_W-1:0] tail_q;

    logic              adv;
    logic [K-1:0]      u_enc;
    logic [N-1:0]      tx_nxt;
    logic [M-1:0]      s_nxt;
    logic [CNT_W-1:0]  cnt_inc;

    // Output register is free when empty or being drained this cycle.
    assign adv     = !tx_valid_q || bus.tx_ready;
    assign u_enc   = (fsm_q == StTail) ? '0 : bus.Din;
    assign cnt_inc = cnt_q + CNT_W'(1);

    assign bus.din_ready = adv && ((fsm_q == StIdle) || (fsm_q == StData));
    assign bus.Tx        = tx_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_first  = tx_first_q;
    assign bus.tx_last   = tx_last_q;

    enc_trellis_322 u_trellis (
        .u      (u_enc),
        .s      (s_q),
        .tx     (tx_nxt),
        .s_next (s_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q      <= StIdle;
            s_q        <= '0;
            tx_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_first_q <= 1'b0;
            tx_last_q  <= 1'b0;
            cnt_q      <= '0;
            tail_q     <= '0;
        end else if (adv) begin
            // No symbol produced unless a branch below says otherwise; Tx keeps its value.
            tx_valid_q <= 1'b0;
            tx_first_q <= 1'b0;
            tx_last_q  <= 1'b0;
            unique case (fsm_q)
                StIdle: begin
                    if (bus.din_valid) begin
                        s_q        <= s_nxt;
                        tx_q       <= tx_nxt;
                        tx_valid_q <= 1'b1;
                        tx_first_q <= 1'b1;
                        cnt_q      <= CNT_W'(1);
                        tail_q     <= '0;
                        fsm_q      <= (FRAME_LEN == 1) ? StTail : StData;
                    end
                end
                StData: begin
                    if (bus.din_valid) begin
                        s_q        <= s_nxt;
                        tx_q       <= tx_nxt;
                        tx_valid_q <= 1'b1;
                        cnt_q      <= cnt_inc;
                        if (cnt_inc == CNT_END) begin
                            tail_q <= '0;
                            fsm_q  <= StTail;
                        end
                    end
                end
                StTail: begin
                    // u_enc is forced to zero here, flushing the shift register.
                    s_q        <= s_nxt;
                    tx_q       <= tx_nxt;
                    tx_valid_q <= 1'b1;
                    tail_q     <= tail_q + TAIL_W'(1);
                    if (tail_q == TAIL_END) begin
                        tx_last_q <= 1'b1;
                        fsm_q     <= StIdle;
                    end
                end
                default: begin
                    fsm_q <= StIdle;
                end
            endcase
        end
    end

endmodule
